sdr_port_responder: RTL and testbench

SDR_PORT_RESPONDER -- requirements
Module: sdr_port_responder

---
 rtl/sdr_port_responder.sv | 144 ++++++++++++++
 tb/tb_sdr_port_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_responder.sv
// rtl/sdr_port_responder.sv - two-port toggle-handshake responder (cpu r/w, scn 2-word read) onto one memory backend
module sdr_port_responder #(
  parameter bit SCN_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  input  logic [31:0] scn_addr,
  input  logic        scn_req,
  output logic        scn_ack,
  output logic [31:0] scn_q,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_burst2,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_sel_scn, r_prefer_scn, r_beat;
  logic        r_rw, r_mem_req, r_burst2;
  logic [31:0] r_addr;
  logic [15:0] r_wdata, r_lo, r_hi;
  logic [1:0]  r_be;
  logic        r_cpu_ack, r_scn_ack;
  logic [15:0] r_cpu_q;
  logic [31:0] r_scn_q;

  logic w_cpu_pend, w_scn_pend, w_grant_scn, w_accept, w_last_beat;
  logic w_unused;

  assign w_cpu_pend  = cpu_req ^ r_cpu_ack;
  assign w_scn_pend  = scn_req ^ r_scn_ack;
  assign w_grant_scn = w_scn_pend && (!w_cpu_pend || r_prefer_scn);
  // First CMD cycle only launches mem_req; acceptance needs it already visible.
  assign w_accept    = r_mem_req && mem_ready;
  assign w_last_beat = mem_rvalid && (!r_sel_scn || r_beat);
  assign w_unused    = ^{cpu_addr[0], scn_addr[1:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_pend || w_scn_pend) begin
          if (!w_grant_scn && !cpu_rw && (cpu_be == 2'b00))
            w_next = S_DONE;
          else
            w_next = S_CMD;
        end
      end
      S_CMD:   if (w_accept) w_next = r_rw ? S_DATA : S_DONE;
      S_DATA:  if (w_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sel_scn    <= 1'b0;
      r_prefer_scn <= SCN_FIRST;
      r_beat       <= 1'b0;
      r_rw         <= 1'b1;
      r_mem_req    <= 1'b0;
      r_burst2     <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 16'd0;
      r_be         <= 2'b00;
      r_lo         <= 16'd0;
      r_hi         <= 16'd0;
      r_cpu_ack    <= 1'b0;
      r_scn_ack    <= 1'b0;
      r_cpu_q      <= 16'd0;
      r_scn_q      <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (r_state == S_CMD) && !w_accept;
      case (r_state)
        S_IDLE: begin
          r_beat <= 1'b0;
          if (w_cpu_pend || w_scn_pend) begin
            r_sel_scn <= w_grant_scn;
            // Tie-break alternates between the two most recent tie winners.
            if (w_cpu_pend && w_scn_pend) r_prefer_scn <= !w_grant_scn;
            if (w_grant_scn) begin
              r_addr   <= {scn_addr[31:2], 2'b00};
              r_rw     <= 1'b1;
              r_be     <= 2'b11;
              r_burst2 <= 1'b1;
            end else begin
              r_addr   <= {cpu_addr[31:1], 1'b0};
              r_rw     <= cpu_rw;
              r_be     <= cpu_be;
              r_wdata  <= cpu_data;
              r_burst2 <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (mem_rvalid) begin
            if (!r_beat) r_lo <= mem_rdata;
            else         r_hi <= mem_rdata;
            r_beat <= 1'b1;
          end
        end
        S_DONE: begin
          if (r_sel_scn) begin
            r_scn_ack <= ~r_scn_ack;
            r_scn_q   <= {r_hi, r_lo};
          end else begin
            r_cpu_ack <= ~r_cpu_ack;
            if (r_rw) r_cpu_q <= r_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack    = r_cpu_ack;
  assign scn_ack    = r_scn_ack;
  assign cpu_q      = r_cpu_q;
  assign scn_q      = r_scn_q;
  assign mem_req    = r_mem_req;
  assign mem_rw     = r_rw;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_be     = r_be;
  assign mem_burst2 = r_burst2;

endmodule

// File: tb/tb_sdr_port_responder.sv
// tb/tb_sdr_port_responder.sv - directed self-checking bench for sdr_port_responder
module tb_sdr_port_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic [15:0] cpu_data;
  logic [1:0]  cpu_be;
  logic        cpu_rw, cpu_req, cpu_ack;
  logic [15:0] cpu_q;
  logic [31:0] scn_addr;
  logic        scn_req, scn_ack;
  logic [31:0] scn_q;
  logic        mem_req, mem_rw, mem_burst2, mem_ready, mem_rvalid;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int t_cpu, t_scn;
  logic old_cpu_ack, old_scn_ack;

  always #5 clk = ~clk;

  sdr_port_responder #(.SCN_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_be(cpu_be), .cpu_rw(cpu_rw),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .scn_addr(scn_addr), .scn_req(scn_req), .scn_ack(scn_ack), .scn_q(scn_q),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_burst2(mem_burst2), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic watch_acks(input int budget);
    old_cpu_ack = cpu_ack;
    old_scn_ack = scn_ack;
    t_cpu = -1;
    t_scn = -1;
    for (int i = 1; i <= budget; i++) begin
      tick;
      if (t_cpu < 0 && cpu_ack !== old_cpu_ack) t_cpu = i;
      if (t_scn < 0 && scn_ack !== old_scn_ack) t_scn = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    cpu_addr = 32'd0; cpu_data = 16'd0; cpu_be = 2'b00; cpu_rw = 1'b1; cpu_req = 1'b0;
    scn_addr = 32'd0; scn_req = 1'b0;
    mem_ready = 1'b0; mem_rdata = 16'd0; mem_rvalid = 1'b0;
    repeat (3) tick;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_scn_ack", scn_ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_burst2", mem_burst2, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_cpu_q", cpu_q, 0);
    chk("rst_scn_q", scn_q, 0);
    reset_n = 1'b1;
    tick;

    // CPU read 0x00100004, beat in second DATA cycle
    cpu_addr = 32'h0010_0004; cpu_rw = 1'b1; cpu_be = 2'b11; mem_ready = 1'b1; cpu_req = 1'b1;
    tick;
    chk("rd_launch_req", mem_req, 0);
    cpu_addr = 32'hFFFF_FFFF; cpu_rw = 1'b0;
    tick;
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h0010_0004);
    chk("rd_mem_rw", mem_rw, 1);
    chk("rd_burst2", mem_burst2, 0);
    tick;
    chk("rd_req_drop", mem_req, 0);
    tick;
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    tick;
    mem_rvalid = 1'b0;
    chk("rd_ack_early", cpu_ack, 0);
    tick;
    chk("rd_ack", cpu_ack, 1);
    chk("rd_cpu_q", cpu_q, 16'hBEEF);
    repeat (3) tick;
    chk("rd_ack_once", cpu_ack, 1);

    // scn 2-beat read 0x13
    scn_addr = 32'h0000_0013; scn_req = 1'b1;
    tick;
    scn_addr = 32'hFFFF_FFFF;
    tick;
    chk("scn_mem_req", mem_req, 1);
    chk("scn_mem_addr", mem_addr, 32'h0000_0010);
    chk("scn_burst2", mem_burst2, 1);
    chk("scn_mem_rw", mem_rw, 1);
    chk("scn_mem_be", mem_be, 2'b11);
    tick;
    mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    tick;
    mem_rdata = 16'h2222;
    tick;
    mem_rvalid = 1'b0;
    chk("scn_ack_early", scn_ack, 0);
    tick;
    chk("scn_ack", scn_ack, 1);
    chk("scn_q", scn_q, 32'h2222_1111);
    chk("scn_cpu_q_hold", cpu_q, 16'hBEEF);

    // CPU write, minimum latency
    cpu_addr = 32'h0000_0101; cpu_data = 16'hCAFE; cpu_be = 2'b11; cpu_rw = 1'b0; cpu_req = 1'b0;
    tick;
    chk("wr_launch_req", mem_req, 0);
    tick;
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_addr", mem_addr, 32'h0000_0100);
    chk("wr_mem_rw", mem_rw, 0);
    chk("wr_wdata", mem_wdata, 16'hCAFE);
    tick;
    chk("wr_ack_early", cpu_ack, 1);
    tick;
    chk("wr_ack", cpu_ack, 0);
    chk("wr_cpu_q_hold", cpu_q, 16'hBEEF);

    // CPU write be=01 with mem_ready low for 5 cycles
    mem_ready = 1'b0;
    cpu_addr = 32'h0000_0202; cpu_data = 16'h1234; cpu_be = 2'b01; cpu_rw = 1'b0; cpu_req = 1'b1;
    tick;
    chk("ws_launch_req", mem_req, 0);
    cpu_data = 16'hFFFF; cpu_be = 2'b10; cpu_addr = 32'h0000_0F00;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("ws_mem_req_hold", mem_req, 1);
      chk("ws_mem_be", mem_be, 2'b01);
      chk("ws_wdata", mem_wdata, 16'h1234);
      chk("ws_mem_addr", mem_addr, 32'h0000_0202);
      if (i == 5) mem_ready = 1'b1;
    end
    tick;
    chk("ws_req_drop", mem_req, 0);
    chk("ws_ack_early", cpu_ack, 0);
    tick;
    chk("ws_ack", cpu_ack, 1);
    chk("ws_cpu_q_hold", cpu_q, 16'hBEEF);

    // CPU write be=00: no backend command
    cpu_be = 2'b00; cpu_rw = 1'b0; cpu_req = 1'b0;
    tick;
    chk("be0_no_req1", mem_req, 0);
    chk("be0_ack_early", cpu_ack, 1);
    tick;
    chk("be0_no_req2", mem_req, 0);
    chk("be0_ack", cpu_ack, 0);
    tick;
    chk("be0_no_req3", mem_req, 0);

    // Simultaneous requests after reset
    cpu_req = 1'b0; scn_req = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    cpu_addr = 32'h0000_0040; cpu_rw = 1'b1; cpu_be = 2'b11; scn_addr = 32'h0000_0080;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
    cpu_req = 1'b1; scn_req = 1'b1;
    watch_acks(20);
    chk("tie1_scn_tick", t_scn, 6);
    chk("tie1_cpu_tick", t_cpu, 11);
    chk("tie1_scn_q", scn_q, 32'h5A5A_5A5A);
    chk("tie1_cpu_q", cpu_q, 16'h5A5A);
    cpu_req = 1'b0; scn_req = 1'b0;
    watch_acks(20);
    chk("tie2_cpu_tick", t_cpu, 5);
    chk("tie2_scn_tick", t_scn, 11);
    mem_rvalid = 1'b0;

    // Reset during DATA abandons the scn read
    scn_addr = 32'h0000_0200; scn_req = 1'b1;
    tick;
    tick;
    chk("ab_mem_req", mem_req, 1);
    tick;
    chk("ab_in_data", mem_req, 0);
    reset_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    repeat (2) tick;
    chk("ab_rst_scn_ack", scn_ack, 0);
    chk("ab_rst_mem_req", mem_req, 0);
    chk("ab_rst_scn_q", scn_q, 0);
    reset_n = 1'b1;
    tick;
    tick;
    chk("ab_regrant_req", mem_req, 1);
    chk("ab_regrant_addr", mem_addr, 32'h0000_0200);
    mem_rvalid = 1'b0;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
    tick;
    mem_rdata = 16'hBBBB;
    tick;
    mem_rvalid = 1'b0;
    chk("ab_ack_early", scn_ack, 0);
    tick;
    chk("ab_ack", scn_ack, 1);
    chk("ab_scn_q", scn_q, 32'hBBBB_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
